instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface. Owns the PC, drives the word address to the combinational instruction_memory and samples the returned instruction.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush buffered work.

Parameters:
- XLEN, 32, address/PC and instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  XLEN  byte address to instruction memory; always equals current PC.
- imem_req  output  1  high when the sampled imem_instr is enqueued this cycle.
- imem_instr  input  XLEN  instruction word; combinational function of imem_addr, same cycle.
- redirect_valid  input  1  one-cycle pulse requesting a PC change.
- redirect_pc  input  XLEN  target PC, qualified by redirect_valid.
- out_valid  output  1  head FIFO entry is valid.
- out_ready  input  1  decode accepts the head entry.
- out_instr  output  XLEN  head instruction; 0 when empty.
- out_pc  output  XLEN  PC of head instruction; 0 when empty.
- fetch_fault  output  1  misaligned-target fault; present only with FETCH_MISALIGN_TRAP_EN.

Behaviour:
- Reset values (asynchronous assert, synchronous use after deassert):
  - pc = RESET_PC, state = BOOT, FIFO empty.
  - imem_req = 0, out_valid = 0, out_instr = 0, out_pc = 0, fetch_fault = 0.
- Reset mid-operation discards everything immediately.
- States:
  - BOOT: one cycle after reset release, imem_req = 0, then go to RUN.
  - RUN: fetching.
  - HALT: fault; reachable only with the macro.
- Enqueue condition (RUN): imem_req = 1 when state == RUN, redirect_valid == 0, and the FIFO has a free slot.
  - A free slot means count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop this cycle (pop-through when full).
  - On the edge, push {pc, imem_instr} and set pc = pc + 4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
- Fetch latency: an instruction appears at out_* one cycle after its address is driven. The first out_valid is the 2nd rising edge after rst_n deasserts.
- Stall: when the FIFO is full with no pop, pc holds and imem_req = 0.
- Pop: on out_valid && out_ready. Head data must be stable while out_valid=1 and out_ready=0.
- Redirect has priority over all other events in the same cycle:
  - FIFO count goes to 0, pc = redirect_pc, no enqueue that cycle.
  - A simultaneous pop counts as a completed transfer to the consumer; its entry is discarded either way.
  - Next cycle imem_addr = redirect_pc.
- Back-to-back redirects: the last one wins.
- Redirect during BOOT: taken, and the state still moves to RUN.
- Misaligned redirect_pc (bits [1:0] != 0) without the macro: low two bits forced to 0.
- Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the FIFO, loads pc unmodified and enters HALT.
  - HALT: imem_req = 0, out_valid = 0, fetch_fault = 1 (sticky).
  - Exits only on reset or on an aligned redirect, which clears fetch_fault and returns to RUN.
- Undefined: no fetch_fault port, no HALT state, low bits masked as above.

Decomposition:
- Shared package riscv_fetch_pkg:
  - XLEN_DEF = 32, PC_INC = 4, NOP_INSTR = 32'h0000_0013.
  - Enum fetch_state_e {BOOT, RUN, HALT}.
  - Packed struct fetch_entry_t {pc, instr}.
- One natural sub-module: fetch_fifo.
  - Parameterised depth; push, pop and flush.
  - Count plus full/empty; flush has priority over push/pop.
  - Holds fetch_entry_t.

Test Plan:
- Bench memory model: instr = addr ^ 32'hA5A5_0000.
- Reset release with out_ready=1: imem_addr sequence 0x0, 0x4, 0x8. out_pc=0x0/instr=0xA5A5_0000 on the 2nd edge, then 0x4/0xA5A5_0004 on the following edge, one per cycle.
- Hold out_ready=0 for 5 cycles: FIFO fills with 2 entries, imem_addr holds at 0x8, imem_req=0, out_pc stays 0x0. Release: entries come out in order 0x0, 0x4, 0x8, with no loss or duplicate.
- Redirect to 0x100 while FIFO holds 0x4 and 0x8: next cycle out_valid=0 and imem_addr=0x100. Following cycle out_pc=0x100, instr=0xA5A5_0100.
- Redirect to 0xFFFF_FFF8: fetched PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Redirect to 0x102:
  - Without macro: fetch resumes at 0x100.
  - With FETCH_MISALIGN_TRAP_EN: fetch_fault=1, out_valid=0, imem_req=0 persists; a redirect to 0x200 clears the fault and out_pc=0x200 follows.
- Assert rst_n=0 mid-stream with FIFO full: outputs go to reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// FETCH_MISALIGN_TRAP_EN: when defined, the state enum gains HALT for
// misaligned-redirect faults.
package riscv_fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] PC_INC = 32'd4;
    localparam logic [XLEN_DEF-1:0] NOP_INSTR = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        BOOT,
        RUN
    } fetch_state_e;
`endif

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

    // Clear the low two bits to form a word-aligned byte address.
    function automatic logic [XLEN_DEF-1:0] align_word(input logic [XLEN_DEF-1:0] addr);
        return {addr[XLEN_DEF-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch_entry_t.
// Ports: clk, rst_n (async active-low), push/pop/flush controls, wdata in,
// rdata (head entry), full/empty status. Flush wins over push and pop.
// A push is accepted when full only if a pop happens in the same cycle.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives a combinational instruction
// memory, buffers {pc, instr} pairs and hands them to decode over valid/ready.
// Ports: clk, rst_n (async active-low); imem_addr/imem_req/imem_instr to
// memory; redirect_valid/redirect_pc from branch resolution; out_valid,
// out_ready, out_instr, out_pc to decode; fetch_fault (FETCH_MISALIGN_TRAP_EN
// only). XLEN must equal XLEN_DEF (entry struct width).
// FETCH_MISALIGN_TRAP_EN: misaligned redirects trap into HALT instead of
// being word-aligned.
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            fetch_fault,
`endif
    output logic [XLEN-1:0] out_pc
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            slot_free;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign fetch_fault = fault_q;
`endif

    assign imem_addr = pc_q;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // Pop-through: a full FIFO still accepts a push when the head leaves.
    assign slot_free = !fifo_full || pop;
    assign imem_req  = (state_q == RUN) && !redirect_valid && slot_free;
    assign out_instr = out_valid ? head_entry.instr : '0;
    assign out_pc    = out_valid ? head_entry.pc : '0;

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_instr;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (imem_req),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_q <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_q <= HALT;
                fault_q <= 1'b1;
            end else begin
                state_q <= RUN;
                fault_q <= 1'b0;
            end
`else
            pc_q    <= align_word(redirect_pc);
            state_q <= RUN;
`endif
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (imem_req) pc_q <= pc_q + XLEN'(PC_INC);
                end
                default: state_q <= state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory model.
    assign imem_instr = imem_addr ^ 32'hA5A5_0000;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault    (fetch_fault),
`endif
        .out_pc         (out_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while held in reset.
        #2;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_req", imem_req, 0);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_fault", fetch_fault, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("boot_req", imem_req, 0);
        check("boot_addr", imem_addr, 32'h0);

        step();  // edge 1: BOOT -> RUN
        check("run_req", imem_req, 1);
        check("run_addr", imem_addr, 32'h0);
        check("run_valid", out_valid, 0);

        step();  // edge 2: first entry visible
        check("first_valid", out_valid, 1);
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'hA5A5_0000);
        check("first_addr", imem_addr, 32'h4);

        // Stall decode: FIFO fills with 0x0 and 0x4.
        out_ready = 1'b0;
        #1;
        check("fill_req", imem_req, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h8);
            check("stall_req", imem_req, 0);
            check("stall_pc", out_pc, 32'h0);
            check("stall_valid", out_valid, 1);
        end

        // Release: pop-through keeps one entry per cycle.
        out_ready = 1'b1;
        #1;
        check("popthru_req", imem_req, 1);
        check("drain0_pc", out_pc, 32'h0);
        step();
        check("drain1_pc", out_pc, 32'h4);
        check("drain1_instr", out_instr, 32'hA5A5_0004);
        check("drain1_addr", imem_addr, 32'hC);
        step();
        check("drain2_pc", out_pc, 32'h8);
        check("drain2_instr", out_instr, 32'hA5A5_0008);

        // Redirect flushes buffered entries.
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("redir_req", imem_req, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("redir_valid", out_valid, 0);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_req2", imem_req, 1);
        step();
        check("redir_pc", out_pc, 32'h100);
        check("redir_instr", out_instr, 32'hA5A5_0100);

        // PC wrap.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        check("wrap_valid0", out_valid, 0);
        step();
        check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        check("wrap_addr2", imem_addr, 32'h0);
        step();
        check("wrap_pc2", out_pc, 32'h0);
        check("wrap_instr2", out_instr, 32'hA5A5_0000);

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            check("halt_fault", fetch_fault, 1);
            check("halt_valid", out_valid, 0);
            check("halt_req", imem_req, 0);
            check("halt_addr", imem_addr, 32'h102);
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        #1;
        check("unhalt_fault", fetch_fault, 0);
        check("unhalt_addr", imem_addr, 32'h200);
        step();
        check("unhalt_pc", out_pc, 32'h200);
        check("unhalt_instr", out_instr, 32'hA5A5_0200);
`else
        check("mask_addr", imem_addr, 32'h100);
        step();
        check("mask_pc", out_pc, 32'h100);
        check("mask_valid", out_valid, 1);
`endif

        // Fill the FIFO, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        step();
        step();
        check("full_req", imem_req, 0);
        check("full_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr", imem_addr, 32'h0);
        check("arst_req", imem_req, 0);
        check("arst_valid", out_valid, 0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_instr", out_instr, 32'h0);

        // Redirect taken during BOOT.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("bootredir_req", imem_req, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("bootredir_addr", imem_addr, 32'h40);
        check("bootredir_run", imem_req, 1);
        step();
        check("bootredir_pc", out_pc, 32'h40);
        check("bootredir_instr", out_instr, 32'hA5A5_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
